// File: rtl/enemy_row_phase_sequencer.sv
// Enemy row driver: frame-tick counting, 4-phase movement FSM, alive/dead tracking
// and a registered {x, y} position word for the renderer and collision logic.
module enemy_row_phase_sequencer #(
    parameter int          STEP_FRAMES       = 8,
    parameter int          STEPS_PER_PHASE   = 32,
    parameter logic [9:0]  START_X           = 10'd320,
    parameter logic [8:0]  VERTICAL_POSITION = 9'd168,
    parameter logic [18:0] NONE              = {19{1'b1}}
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_FrameTick,
    input  logic        i_Enable,
    input  logic        i_Kill,
    input  logic        i_Respawn,
    output logic [1:0]  o_PhaseState,
    output logic        o_EnemyState,
    output logic [18:0] o_EnemyPosition,
    output logic        o_StepPulse
);

    localparam int FW = (STEP_FRAMES > 1)     ? $clog2(STEP_FRAMES)     : 1;
    localparam int SW = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(STEP_FRAMES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_PHASE - 1);

    typedef enum logic [1:0] {
        PH_LEFT_A  = 2'b00,
        PH_RIGHT_A = 2'b01,
        PH_RIGHT_B = 2'b10,
        PH_LEFT_B  = 2'b11
    } phase_t;

    phase_t        r_Phase,    w_PhaseNext;
    logic [FW-1:0] r_FrameCnt, w_FrameCntNext;
    logic [SW-1:0] r_StepCnt,  w_StepCntNext;
    logic [9:0]    r_X,        w_XNext;
    logic          r_Alive,    w_AliveNext;
    logic          r_StepPulse, w_StepPulseNext;
    logic [18:0]   r_Position, w_PositionNext;
    logic          w_Accept;

    assign w_Accept = i_FrameTick & i_Enable & r_Alive & ~i_Kill & ~i_Respawn;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Phase     <= PH_LEFT_A;
            r_FrameCnt  <= '0;
            r_StepCnt   <= '0;
            r_X         <= START_X;
            r_Alive     <= 1'b1;
            r_StepPulse <= 1'b0;
            r_Position  <= {START_X, VERTICAL_POSITION};
        end else begin
            r_Phase     <= w_PhaseNext;
            r_FrameCnt  <= w_FrameCntNext;
            r_StepCnt   <= w_StepCntNext;
            r_X         <= w_XNext;
            r_Alive     <= w_AliveNext;
            r_StepPulse <= w_StepPulseNext;
            r_Position  <= w_PositionNext;
        end
    end

    always_comb begin
        w_PhaseNext     = r_Phase;
        w_FrameCntNext  = r_FrameCnt;
        w_StepCntNext   = r_StepCnt;
        w_XNext         = r_X;
        w_AliveNext     = r_Alive;
        w_StepPulseNext = 1'b0;

        if (i_Respawn) begin
            w_AliveNext    = 1'b1;
            w_XNext        = START_X;
            w_PhaseNext    = PH_LEFT_A;
            w_FrameCntNext = '0;
            w_StepCntNext  = '0;
        end else if (i_Kill) begin
            w_AliveNext = 1'b0;
        end else if (w_Accept) begin
            if (r_FrameCnt == FRAME_LAST) begin
                w_FrameCntNext  = '0;
                w_StepPulseNext = 1'b1;
                // direction comes from the phase in force before any advance
                if (r_Phase == PH_LEFT_A || r_Phase == PH_LEFT_B)
                    w_XNext = r_X - 10'd1;
                else
                    w_XNext = r_X + 10'd1;
                if (r_StepCnt == STEP_LAST) begin
                    w_StepCntNext = '0;
                    case (r_Phase)
                        PH_LEFT_A:  w_PhaseNext = PH_RIGHT_A;
                        PH_RIGHT_A: w_PhaseNext = PH_RIGHT_B;
                        PH_RIGHT_B: w_PhaseNext = PH_LEFT_B;
                        default:    w_PhaseNext = PH_LEFT_A;
                    endcase
                end else begin
                    w_StepCntNext = r_StepCnt + 1'b1;
                end
            end else begin
                w_FrameCntNext = r_FrameCnt + 1'b1;
            end
        end

        w_PositionNext = w_AliveNext ? {w_XNext, VERTICAL_POSITION} : NONE;
    end

    assign o_PhaseState    = r_Phase;
    assign o_EnemyState    = r_Alive;
    assign o_EnemyPosition = r_Position;
    assign o_StepPulse     = r_StepPulse;

endmodule

// File: tb/tb_enemy_row_phase_sequencer.sv
// Scoreboard bench: stimulus pushes expected step results, a monitor pops them on
// every o_StepPulse; directed checks cover reset, milestones, kill and respawn.
module tb_enemy_row_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, en = 1'b1, kill = 1'b0, resp = 1'b0;
    logic [1:0]  phase;
    logic        alive;
    logic [18:0] pos;
    logic        pulse;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] sb_q[$];   // {x[9:0], phase[1:0]} expected per step

    logic [9:0] m_x;
    logic [1:0] m_ph;
    int         m_fc, m_sc;
    logic       m_alive;

    enemy_row_phase_sequencer dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_FrameTick(tick), .i_Enable(en),
        .i_Kill(kill), .i_Respawn(resp), .o_PhaseState(phase),
        .o_EnemyState(alive), .o_EnemyPosition(pos), .o_StepPulse(pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_spawn();
        m_x = 10'd320; m_ph = 2'd0; m_fc = 0; m_sc = 0; m_alive = 1'b1;
    endtask

    // one stimulus cycle, then one idle cycle; the model predicts the step result
    task automatic cyc(input logic t, input logic k, input logic r);
        @(negedge clk);
        tick = t; kill = k; resp = r;
        if (r) model_spawn();
        else if (k) m_alive = 1'b0;
        else if (t && en && m_alive) begin
            if (m_fc == 7) begin
                m_fc = 0;
                m_x = (m_ph == 2'd0 || m_ph == 2'd3) ? m_x - 10'd1 : m_x + 10'd1;
                if (m_sc == 31) begin m_sc = 0; m_ph = m_ph + 2'd1; end
                else m_sc++;
                sb_q.push_back({m_x, m_ph});
            end else m_fc++;
        end
        @(negedge clk);
        tick = 1'b0; kill = 1'b0; resp = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_pos(input string name, input logic [9:0] x, input logic [1:0] ph);
        chk({name, "_pos"}, 32'(pos), 32'({x, 9'd168}));
        chk({name, "_phase"}, 32'(phase), 32'(ph));
    endtask

    always @(posedge clk) begin
        #1;
        if (pulse) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL step_unexpected: pulse with x=%0d phase=%0d, none expected",
                         pos[18:9], phase);
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                if ({pos[18:9], phase} !== e) begin
                    n_err++;
                    $display("FAIL step_result: got x=%0d ph=%0d expected x=%0d ph=%0d",
                             pos[18:9], phase, e[11:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        model_spawn();
        #12;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_alive", 32'(alive), 32'd1);
        chk("rst_pos",   32'(pos),   32'({10'd320, 9'd168}));
        chk("rst_pulse", 32'(pulse), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        ticks(8);
        chk_pos("tick8", 10'd319, 2'd0);
        chk("tick8_pulse", 32'(pulse), 32'd1);
        @(negedge clk);
        chk("pulse_width", 32'(pulse), 32'd0);

        ticks(248);  chk_pos("tick256", 10'd288, 2'd1);
        ticks(256);  chk_pos("tick512", 10'd320, 2'd2);
        ticks(256);  chk_pos("tick768", 10'd352, 2'd3);
        ticks(256);  chk_pos("tick1024", 10'd320, 2'd0);

        // disable window in mid-step must not disturb the frame counter
        ticks(3);
        en = 1'b0; ticks(20); chk_pos("disabled", 10'd320, 2'd0);
        en = 1'b1; ticks(4);  chk_pos("reenable_nostep", 10'd320, 2'd0);
        ticks(1);             chk_pos("reenable_step", 10'd319, 2'd0);

        cyc(1'b0, 1'b0, 1'b1);
        ticks(7);
        cyc(1'b1, 1'b1, 1'b0);
        chk("kill_alive", 32'(alive), 32'd0);
        chk("kill_pos",   32'(pos),   32'h7FFFF);
        ticks(10);
        chk("dead_pos",   32'(pos),   32'h7FFFF);
        chk("dead_phase", 32'(phase), 32'd0);

        cyc(1'b0, 1'b0, 1'b1);
        ticks(256 + 96);
        chk_pos("at300", 10'd300, 2'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("dead300_phase", 32'(phase), 32'd1);
        chk("dead300_alive", 32'(alive), 32'd0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("resp_alive", 32'(alive), 32'd1);
        chk_pos("resp", 10'd320, 2'd0);
        ticks(7); chk_pos("resp_nostep", 10'd320, 2'd0);
        ticks(1); chk_pos("resp_step", 10'd319, 2'd0);

        ticks(3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("killresp_alive", 32'(alive), 32'd1);
        chk_pos("killresp", 10'd320, 2'd0);
        ticks(8); chk_pos("killresp_step", 10'd319, 2'd0);

        ticks(32);
        chk_pos("prereset", 10'd315, 2'd0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_phase", 32'(phase), 32'd0);
        chk("async_alive", 32'(alive), 32'd1);
        chk("async_pos",   32'(pos),   32'({10'd320, 9'd168}));
        chk("async_pulse", 32'(pulse), 32'd0);
        model_spawn();
        @(negedge clk); rst_n = 1'b1;
        ticks(8); chk_pos("postreset_step", 10'd319, 2'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
